flags_write_arbiter: RTL

- Shares the 4-bit flags register between NUM_REQ producers, e.g. ALU, shifter, compare unit and the flag-load instruction.
- Each cycle it grants at most one valid requester, round-robin.
- It merges the requester's masked flag bits into a shadow copy of the flags and drives the flags register's write enable and data one cycle later.
- Sits between execute-stage units and the flags register; it is the only writer of that register.

---
 rtl/flags_write_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flags_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : flags_write_arbiter
// Purpose  : Round-robin arbiter that is the single writer of the 4-bit flags
//            register. Each cycle at most one valid requester is granted; its
//            masked flag bits are merged into a shadow copy of the flags, and
//            the merged value is presented to the flags register one cycle
//            later.
// Ports    : clk          - system clock
//            rst          - synchronous, active-low reset
//            req_valid    - per-requester write request
//            req_flags    - requested flag values, slice [i*FLAG_W +: FLAG_W]
//            req_mask     - per-bit update mask, same slicing as req_flags
//            req_ready    - one-hot grant (combinational)
//            freeze       - pipeline stall, blocks all grants
//            flags_we     - flags register write enable
//            flags_d      - flags register write data
//            flags_shadow - architectural flags including in-flight writes
//            grant_id     - index of the last accepted requester
//            busy         - high while flags_we is high
// Option   : FLAGS_ARB_SAVE_RESTORE_EN adds save_req / restore_req inputs,
//            the saved_flags output and a one-entry save slot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flags_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FLAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLAG_W-1:0]     req_flags,
  input  logic [NUM_REQ*FLAG_W-1:0]     req_mask,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          freeze,
  output logic                          flags_we,
  output logic [FLAG_W-1:0]             flags_d,
  output logic [FLAG_W-1:0]             flags_shadow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FLAGS_ARB_SAVE_RESTORE_EN
  ,
  input  logic                          save_req,
  input  logic                          restore_req,
  output logic [FLAG_W-1:0]             saved_flags
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state, next_state;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic [PW:0]       cand;
  logic              accept;
  logic              restore;
  logic [FLAG_W-1:0] merged;
  logic [FLAG_W-1:0] flag_arr [NUM_REQ];
  logic [FLAG_W-1:0] mask_arr [NUM_REQ];

  // Unpack the flat request buses into per-requester slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign flag_arr[gi] = req_flags[gi*FLAG_W +: FLAG_W];
      assign mask_arr[gi] = req_mask[gi*FLAG_W +: FLAG_W];
    end
  endgenerate

`ifdef FLAGS_ARB_SAVE_RESTORE_EN
  logic [FLAG_W-1:0] slot;
  assign restore     = restore_req;
  assign saved_flags = slot;
`else
  assign restore = 1'b0;
`endif

  // Rotating priority scan: the first valid requester at or above rr_ptr
  // (modulo NUM_REQ) wins. The candidate is one bit wider so the wrap can be
  // done with a single compare-and-subtract.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  // Restore preempts every requester, even while frozen.
  assign accept = win_found && !freeze && rst && !restore;
  assign merged = (flags_shadow & ~mask_arr[win_idx]) |
                  (flag_arr[win_idx] & mask_arr[win_idx]);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: any write launched this cycle (accept or restore) keeps the
  // write port busy next cycle.
  always_comb begin
    next_state = IDLE;
    if (accept || restore) begin
      next_state = WRITE;
    end
  end

  assign flags_we = (state == WRITE);
  assign busy     = (state == WRITE);

  // Shadow / write data / pointer datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_shadow <= '0;
      flags_d      <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
    end else if (restore) begin
`ifdef FLAGS_ARB_SAVE_RESTORE_EN
      flags_shadow <= slot;
      flags_d      <= slot;
`endif
    end else if (accept) begin
      flags_shadow <= merged;
      flags_d      <= merged;
      grant_id     <= win_idx;
      rr_ptr       <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

`ifdef FLAGS_ARB_SAVE_RESTORE_EN
  // Save captures the value the shadow will hold after this edge, so a save
  // coinciding with an accept records the merged result. Restore wins over
  // a concurrent save and leaves the slot untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot <= '0;
    end else if (save_req && !restore_req) begin
      slot <= accept ? merged : flags_shadow;
    end
  end
`endif

endmodule

`default_nettype wire
